// File: rtl/_64b66b_pkg.sv
// Shared definitions for the 64b/66b PCS: sync header codes, block-lock
// state encoding and default lock-window limits.
package _64b66b_pkg;

   typedef enum logic [1:0] {
      RESET = 2'd0,
      TEST  = 2'd1,
      SLIP  = 2'd2,
      WAIT  = 2'd3
   } sync_state_t;

   localparam logic [1:0] SH_DATA = 2'b01;
   localparam logic [1:0] SH_CTRL = 2'b10;

   localparam int SH_CNT_MAX_DEF = 64;
   localparam int SH_INV_MAX_DEF = 16;

   // Only the two transition patterns mark a real block boundary.
   function automatic logic sh_valid(input logic [1:0] head);
      return (head == SH_DATA) || (head == SH_CTRL);
   endfunction

endpackage

// File: rtl/_64b66b_block_sync.sv
// Receive block lock: hunts for the 66-bit block boundary by slipping the
// gearbox one bit at a time and holds lock while sync headers stay valid.
module _64b66b_block_sync
   import _64b66b_pkg::*;
#(
   parameter int SH_CNT_MAX = SH_CNT_MAX_DEF,
   parameter int SH_INV_MAX = SH_INV_MAX_DEF,
   parameter int SLIP_WAIT  = 4
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       valid_i,
   input  logic [1:0] head_i,
   output logic       slip_o,
   output logic       lock_o
);

   localparam int CW = $clog2(SH_CNT_MAX + 1);
   localparam int IW = $clog2(SH_INV_MAX + 1);
   localparam int WW = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

   sync_state_t   state_r;
   logic [CW-1:0] sh_cnt_r;
   logic [IW-1:0] sh_inv_cnt_r;
   logic [WW-1:0] wait_cnt_r;
   logic          slip_r;
   logic          lock_r;

   logic          hdr_ok_s;
   logic [CW-1:0] cnt_inc_s;
   logic [IW-1:0] inv_inc_s;
   logic          cnt_full_s;
   logic          inv_full_s;

   // Header check and next-count candidates for the header sampled this cycle.
   always_comb begin
      hdr_ok_s   = sh_valid(head_i);
      cnt_inc_s  = sh_cnt_r + CW'(1);
      inv_inc_s  = sh_inv_cnt_r + (hdr_ok_s ? IW'(0) : IW'(1));
      cnt_full_s = (cnt_inc_s == CW'(SH_CNT_MAX));
      inv_full_s = (inv_inc_s == IW'(SH_INV_MAX));
   end

   // Lock FSM with its window counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_r      <= RESET;
         sh_cnt_r     <= '0;
         sh_inv_cnt_r <= '0;
         wait_cnt_r   <= '0;
         slip_r       <= 1'b0;
         lock_r       <= 1'b0;
      end else begin
         slip_r <= 1'b0;
         case (state_r)
            RESET: begin
               state_r <= TEST;
            end
            TEST: begin
               if (valid_i) begin
                  if (!lock_r) begin
                     // While hunting, a single bad header means wrong alignment.
                     if (!hdr_ok_s) begin
                        state_r      <= SLIP;
                        slip_r       <= 1'b1;
                        sh_cnt_r     <= '0;
                        sh_inv_cnt_r <= '0;
                     end else if (cnt_full_s) begin
                        lock_r       <= 1'b1;
                        sh_cnt_r     <= '0;
                        sh_inv_cnt_r <= '0;
                     end else begin
                        sh_cnt_r <= cnt_inc_s;
                     end
                  end else begin
                     // Invalid limit is checked first so it wins on the window's last header.
                     if (inv_full_s) begin
                        state_r      <= SLIP;
                        slip_r       <= 1'b1;
                        lock_r       <= 1'b0;
                        sh_cnt_r     <= '0;
                        sh_inv_cnt_r <= '0;
                     end else if (cnt_full_s) begin
                        sh_cnt_r     <= '0;
                        sh_inv_cnt_r <= '0;
                     end else begin
                        sh_cnt_r     <= cnt_inc_s;
                        sh_inv_cnt_r <= inv_inc_s;
                     end
                  end
               end
            end
            SLIP: begin
               state_r      <= WAIT;
               wait_cnt_r   <= WW'(SLIP_WAIT - 1);
               sh_cnt_r     <= '0;
               sh_inv_cnt_r <= '0;
            end
            WAIT: begin
               if (wait_cnt_r == WW'(0)) begin
                  state_r <= TEST;
               end else begin
                  wait_cnt_r <= wait_cnt_r - WW'(1);
               end
            end
            default: begin
               state_r <= RESET;
            end
         endcase
      end
   end

   assign slip_o = slip_r;
   assign lock_o = lock_r;

endmodule

// File: tb/tb__64b66b_block_sync.sv
// Scoreboard bench for the block-lock FSM: a behavioural model predicts
// lock/slip for every driven cycle; each scenario task checks them inline.
module tb__64b66b_block_sync;

   logic       clk     = 1'b0;
   logic       nreset  = 1'b0;
   logic       valid_i = 1'b0;
   logic [1:0] head_i  = 2'b00;
   logic       slip_o;
   logic       lock_o;

   localparam int CNT_MAX = 64;
   localparam int INV_MAX = 16;
   localparam int SW      = 4;

   always #5 clk = ~clk;

   _64b66b_block_sync #(
      .SH_CNT_MAX(CNT_MAX),
      .SH_INV_MAX(INV_MAX),
      .SLIP_WAIT (SW)
   ) dut (
      .clk    (clk),
      .nreset (nreset),
      .valid_i(valid_i),
      .head_i (head_i),
      .slip_o (slip_o),
      .lock_o (lock_o)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [1:0] exp_q[$];

   // Model: after a slip, the slip cycle plus SW wait cycles are blacked out.
   bit m_run, m_lock, m_slip;
   int m_cnt, m_inv, m_blk;

   task automatic model_step(input logic r, input logic v, input logic [1:0] h);
      bit ok;
      bit do_slip;
      do_slip = 1'b0;
      if (!r) begin
         m_run = 0; m_lock = 0; m_slip = 0; m_cnt = 0; m_inv = 0; m_blk = 0;
      end else if (!m_run) begin
         m_run = 1; m_slip = 0;
      end else if (m_blk > 0) begin
         m_blk--; m_slip = 0;
      end else begin
         m_slip = 0;
         if (v) begin
            ok = (h == 2'b01) || (h == 2'b10);
            m_cnt++;
            if (!ok) m_inv++;
            if (!m_lock && !ok) do_slip = 1'b1;
            else if (m_lock && m_inv == INV_MAX) do_slip = 1'b1;
            else if (m_cnt == CNT_MAX) begin
               m_lock = 1; m_cnt = 0; m_inv = 0;
            end
         end
         if (do_slip) begin
            m_lock = 0; m_slip = 1; m_cnt = 0; m_inv = 0; m_blk = SW + 1;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic [1:0] h);
      @(negedge clk);
      nreset  = r;
      valid_i = v;
      head_i  = h;
      model_step(r, v, h);
      exp_q.push_back({m_lock, m_slip});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [1:0] e;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 2'b01);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL reset[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
      end
      n_checks++;
      if ({lock_o, slip_o} !== 2'b00) begin
         n_fail++; $display("FAIL reset_outputs: lock,slip=%b required 00", {lock_o, slip_o});
      end
      cyc(1'b1, 1'b0, 2'b00);
      e = exp_q.pop_front(); n_checks++;
      if ({lock_o, slip_o} !== e) begin
         n_fail++; $display("FAIL reset_release: lock,slip=%b required %b", {lock_o, slip_o}, e);
      end
   endtask

   task automatic test_lock();
      logic [1:0] e;
      int slips = 0;
      for (int i = 0; i < CNT_MAX; i++) begin
         cyc(1'b1, 1'b1, 2'b01);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL lock[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (slip_o === 1'b1) slips++;
         if (i == CNT_MAX - 2) begin
            n_checks++;
            if (lock_o !== 1'b0) begin
               n_fail++; $display("FAIL lock_early: lock=%b required 0", lock_o);
            end
         end
      end
      n_checks++;
      if (lock_o !== 1'b1 || slips != 0) begin
         n_fail++; $display("FAIL lock_rise: lock=%b slips=%0d required lock 1 slips 0", lock_o, slips);
      end
   endtask

   task automatic test_slip_unlocked();
      logic [1:0] e;
      logic [1:0] h;
      int slips = 0;
      cyc(1'b0, 1'b0, 2'b00);
      void'(exp_q.pop_front());
      cyc(1'b1, 1'b0, 2'b00);
      void'(exp_q.pop_front());
      for (int i = 0; i < 11 + SW + 1 + CNT_MAX; i++) begin
         if (i < 10)                h = 2'b01;
         else if (i == 10)          h = 2'b11;
         else if (i < 11 + SW + 1)  h = (i % 2 == 0) ? 2'b00 : 2'b11;
         else                       h = 2'b10;
         cyc(1'b1, 1'b1, h);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL slip_unlocked[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (slip_o === 1'b1) slips++;
         if (i == 10) begin
            n_checks++;
            if (slip_o !== 1'b1) begin
               n_fail++; $display("FAIL slip_pulse: slip=%b required 1", slip_o);
            end
         end
      end
      n_checks++;
      if (slips != 1 || lock_o !== 1'b1) begin
         n_fail++; $display("FAIL slip_relock: slips=%0d lock=%b required 1 and 1", slips, lock_o);
      end
   endtask

   task automatic test_window_inv();
      logic [1:0] e;
      int slips = 0;
      for (int i = 0; i < CNT_MAX; i++) begin
         cyc(1'b1, 1'b1, (i % 4 == 1 && i < 60) ? 2'b00 : 2'b01);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL win15[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (slip_o === 1'b1) slips++;
      end
      n_checks++;
      if (lock_o !== 1'b1 || slips != 0) begin
         n_fail++; $display("FAIL win15_keep: lock=%b slips=%0d required 1 and 0", lock_o, slips);
      end
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         cyc(1'b1, 1'b1, (i % 4 == 1) ? 2'b00 : 2'b01);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL win16[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (i == 61) begin
            n_checks++;
            if ({lock_o, slip_o} !== 2'b01) begin
               n_fail++; $display("FAIL win16_drop: lock,slip=%b required 01", {lock_o, slip_o});
            end
         end
      end
      for (int i = 0; i < CNT_MAX; i++) begin
         cyc(1'b1, 1'b1, 2'b01);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL win_relock[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
      end
   endtask

   task automatic test_boundary();
      logic [1:0] e;
      for (int i = 0; i < CNT_MAX + SW + 1; i++) begin
         cyc(1'b1, 1'b1, (i >= CNT_MAX - INV_MAX) ? 2'b00 : 2'b10);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL boundary[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (i == CNT_MAX - 1) begin
            n_checks++;
            if ({lock_o, slip_o} !== 2'b01) begin
               n_fail++; $display("FAIL boundary_slip_wins: lock,slip=%b required 01", {lock_o, slip_o});
            end
         end
      end
   endtask

   task automatic test_toggle();
      logic [1:0] e;
      for (int i = 0; i < 4 * CNT_MAX; i++) begin
         if (i % 2 == 0) cyc(1'b1, 1'b1, (i >= 2 * CNT_MAX) ? 2'b10 : 2'b01);
         else            cyc(1'b1, 1'b0, 2'b00);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL toggle[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (i == 2 * CNT_MAX - 4 || i == 2 * CNT_MAX - 2) begin
            n_checks++;
            if (lock_o !== (i == 2 * CNT_MAX - 2)) begin
               n_fail++; $display("FAIL toggle_lock_edge[%0d]: lock=%b required %b", i, lock_o, (i == 2 * CNT_MAX - 2));
            end
         end
      end
      n_checks++;
      if (lock_o !== 1'b1) begin
         n_fail++; $display("FAIL toggle_keep: lock=%b required 1", lock_o);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] e;
      int slips = 0;
      // Reset while locked.
      cyc(1'b0, 1'b1, 2'b01);
      e = exp_q.pop_front(); n_checks++;
      if ({lock_o, slip_o} !== 2'b00 || e !== 2'b00) begin
         n_fail++; $display("FAIL reset_locked: lock,slip=%b required 00", {lock_o, slip_o});
      end
      cyc(1'b1, 1'b0, 2'b00);
      void'(exp_q.pop_front());
      // Provoke a slip, then reset in the middle of the wait.
      for (int i = 0; i < 8; i++) begin
         cyc((i == 7) ? 1'b0 : 1'b1, 1'b1, (i < 4) ? 2'b01 : 2'b11);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL reset_wait[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
      end
      n_checks++;
      if ({lock_o, slip_o} !== 2'b00) begin
         n_fail++; $display("FAIL reset_wait_out: lock,slip=%b required 00", {lock_o, slip_o});
      end
      cyc(1'b1, 1'b0, 2'b00);
      void'(exp_q.pop_front());
      for (int i = 0; i < CNT_MAX + 4; i++) begin
         cyc(1'b1, 1'b1, 2'b01);
         e = exp_q.pop_front(); n_checks++;
         if ({lock_o, slip_o} !== e) begin
            n_fail++; $display("FAIL reset_relock[%0d]: lock,slip=%b required %b", i, {lock_o, slip_o}, e);
         end
         if (slip_o === 1'b1) slips++;
      end
      n_checks++;
      if (lock_o !== 1'b1 || slips != 0) begin
         n_fail++; $display("FAIL reset_relock_end: lock=%b slips=%0d required 1 and 0", lock_o, slips);
      end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_slip_unlocked();
      test_window_inv();
      test_boundary();
      test_toggle();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
